mod_mult_controller: RTL and testbench

Finite-state controller that sequences the 8-bit interleaved modular-multiplication datapath to compute C = (A·B) mod N. It sits beside the datapath, driving its 15-bit `Control_Signal` bus and reading its 3-bit `Status_Signal` bus. A host starts an operation with a one-cycle `Start` and is told when it finishes by a one-cycle `Done`. The result stays on the datapath `C` output until the next operation loads new operands.

---
 rtl/mod_mult_controller.sv | 182 ++++++++++++++++++
 tb/tb_mod_mult_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mult_controller.sv
// -----------------------------------------------------------------------------
// mod_mult_controller
//
// Sequencer for the K-bit interleaved modular-multiplication datapath that
// computes C = (A*B) mod N. Each of the K iterations doubles C, reduces it,
// conditionally adds A (when the current MSB of B is set), reduces again,
// then shifts B and decrements the iteration counter held in the datapath.
//
// Host handshake: a one-cycle Start is accepted only while the controller
// is IDLE (Busy=0) and is ignored otherwise. Busy stays high from the cycle
// after acceptance until DONE is left. Done is a single-cycle pulse, and the
// datapath C output holds the result from that cycle until the next LOAD.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset (shared with the datapath)
//   Start          begin an operation (sampled in IDLE only)
//   Status_Signal  [0] B-register MSB, [2:1] comparator result
//                  (2'b10 equal, 2'b01 Op1>Op2, 2'b00 Op1<Op2)
//   Control_Signal [14..0] LoadA, LoadN, LoadCoun, LoadB, ShiftB, LoadC,
//                  ShiftC, S_Coun, S_Comp1, S_Comp2, S_AS1, S_AS2[1:0],
//                  S_C, AS
//   Busy           high in every state except IDLE
//   Done           one-cycle pulse in DONE
//   dbg_state      current FSM state, for debug visibility
//   dbg_iter       number of completed iterations of the current operation
// -----------------------------------------------------------------------------
module mod_mult_controller #(
  parameter int K = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Start,
  input  logic [2:0]                 Status_Signal,
  output logic [14:0]                Control_Signal,
  output logic                       Busy,
  output logic                       Done,
  output logic [3:0]                 dbg_state,
  output logic [$clog2(K+1)-1:0]     dbg_iter
);

  // Control bus bit positions
  localparam int B_LOAD_A    = 14;
  localparam int B_LOAD_N    = 13;
  localparam int B_LOAD_COUN = 12;
  localparam int B_LOAD_B    = 11;
  localparam int B_SHIFT_B   = 10;
  localparam int B_LOAD_C    = 9;
  localparam int B_SHIFT_C   = 8;
  localparam int B_S_COUN    = 7;
  localparam int B_S_COMP1   = 6;
  localparam int B_S_COMP2   = 5;
  localparam int B_S_AS1     = 4;
  localparam int B_S_AS2_HI  = 3;
  localparam int B_S_AS2_LO  = 2;
  localparam int B_S_C       = 1;
  localparam int B_AS        = 0;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LOAD  = 4'd1,
    S_CHECK = 4'd2,
    S_SHIFT = 4'd3,
    S_RED1  = 4'd4,
    S_ADD   = 4'd5,
    S_RED2  = 4'd6,
    S_NEXT  = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [$clog2(K+1)-1:0]    iter;

  // The comparator code 2'b11 is not expected but is treated as >=.
  logic geq;
  logic cmp_equal;
  logic b_msb;

  assign geq       = Status_Signal[2] | Status_Signal[1];
  assign cmp_equal = (Status_Signal[2:1] == 2'b10);
  assign b_msb     = Status_Signal[0];

  assign dbg_state = state;
  assign dbg_iter  = iter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      iter  <= '0;
    end else begin
      state <= state_next;
      if (state == S_LOAD) begin
        iter <= '0;
      end else if (state == S_NEXT) begin
        iter <= iter + 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state;
    Control_Signal = '0;
    Busy           = 1'b1;
    Done           = 1'b0;

    case (state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          state_next = S_LOAD;
        end
      end

      // Counter <= K (S_Coun=0) and C <= 0 (S_C=0) alongside operand loads.
      S_LOAD: begin
        Control_Signal[B_LOAD_A]    = 1'b1;
        Control_Signal[B_LOAD_N]    = 1'b1;
        Control_Signal[B_LOAD_COUN] = 1'b1;
        Control_Signal[B_LOAD_B]    = 1'b1;
        Control_Signal[B_LOAD_C]    = 1'b1;
        state_next = S_CHECK;
      end

      // Comparator selects (0,0) put Counter against zero.
      S_CHECK: begin
        state_next = cmp_equal ? S_DONE : S_SHIFT;
      end

      S_SHIFT: begin
        Control_Signal[B_SHIFT_C] = 1'b1;
        state_next = S_RED1;
      end

      // Compare C with N; subtract N from C when C >= N.
      S_RED1, S_RED2: begin
        Control_Signal[B_S_COMP1] = 1'b1;
        Control_Signal[B_S_COMP2] = 1'b1;
        if (geq) begin
          Control_Signal[B_LOAD_C]   = 1'b1;
          Control_Signal[B_S_C]      = 1'b1;
          Control_Signal[B_S_AS1]    = 1'b1;
          Control_Signal[B_S_AS2_LO] = 1'b1;
          Control_Signal[B_AS]       = 1'b1;
        end
        state_next = (state == S_RED1) ? S_ADD : S_NEXT;
      end

      // C <= C + A when the current B bit is set.
      S_ADD: begin
        if (b_msb) begin
          Control_Signal[B_LOAD_C]   = 1'b1;
          Control_Signal[B_S_C]      = 1'b1;
          Control_Signal[B_S_AS1]    = 1'b1;
          Control_Signal[B_S_AS2_HI] = 1'b1;
        end
        state_next = S_RED2;
      end

      // Shift B and Counter <= Counter - 1 through the add/sub unit
      // (S_AS1=0 picks Counter, S_AS2=00 picks constant 1, AS=1 subtracts).
      S_NEXT: begin
        Control_Signal[B_SHIFT_B]   = 1'b1;
        Control_Signal[B_LOAD_COUN] = 1'b1;
        Control_Signal[B_S_COUN]    = 1'b1;
        Control_Signal[B_AS]        = 1'b1;
        state_next = S_CHECK;
      end

      S_DONE: begin
        Done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        Busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_mult_controller.sv
// -----------------------------------------------------------------------------
// tb_mod_mult_controller
//
// Drives mod_mult_controller together with a behavioural model of the K-bit
// interleaved modular-multiplication datapath. The final C of every operation
// is compared with (A*B) mod N computed by plain arithmetic; control words,
// latency, Busy/Done behaviour, reset and Start-handling are checked against
// constants taken from the cycle schedule of the controller.
// -----------------------------------------------------------------------------
module tb_mod_mult_controller;

  localparam int K = 8;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Status_Signal = 3'b000;
  logic [14:0] Control_Signal;
  logic        Busy;
  logic        Done;
  logic [3:0]  dbg_state;
  logic [3:0]  dbg_iter;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mod_mult_controller #(.K(K)) dut (
    .clk            (clk),
    .rst            (rst),
    .Start          (Start),
    .Status_Signal  (Status_Signal),
    .Control_Signal (Control_Signal),
    .Busy           (Busy),
    .Done           (Done),
    .dbg_state      (dbg_state),
    .dbg_iter       (dbg_iter)
  );

  // ------------------------------------------------------------ datapath model
  logic [7:0] a_in = '0, b_in = '0, n_in = '0;
  logic [7:0] a_reg = '0, n_reg = '0, b_reg = '0, c_reg = '0, cnt_reg = '0;
  logic [7:0] as_op1, as_op2, as_res;

  always_comb begin
    as_op1 = Control_Signal[4] ? c_reg : cnt_reg;
    case (Control_Signal[3:2])
      2'b01:   as_op2 = n_reg;
      2'b10:   as_op2 = a_reg;
      default: as_op2 = 8'd1;
    endcase
    as_res = Control_Signal[0] ? (as_op1 - as_op2) : (as_op1 + as_op2);
  end

  always @(posedge clk) begin
    if (Control_Signal[14]) a_reg <= a_in;
    if (Control_Signal[13]) n_reg <= n_in;
    if (Control_Signal[11]) b_reg <= b_in;
    else if (Control_Signal[10]) b_reg <= b_reg << 1;
    if (Control_Signal[9]) c_reg <= Control_Signal[1] ? as_res : 8'd0;
    else if (Control_Signal[8]) c_reg <= c_reg << 1;
    if (Control_Signal[12]) cnt_reg <= Control_Signal[7] ? as_res : 8'(K);
  end

  function automatic logic [1:0] cmp(input logic [7:0] x, input logic [7:0] y);
    if (x == y) return 2'b10;
    if (x > y)  return 2'b01;
    return 2'b00;
  endfunction

  // Comparator operand select bits depend on the state only, so they are
  // settled shortly after the edge; the status is refreshed from them.
  always begin
    @(posedge clk);
    #1;
    Status_Signal = {(Control_Signal[6] ? cmp(c_reg, n_reg) : cmp(cnt_reg, 8'd0)),
                     b_reg[7]};
  end

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load and shift of the same register never coincide.
  always @(negedge clk) begin
    if (!rst) begin
      check("load_shift_excl",
            32'((Control_Signal[11] & Control_Signal[10]) |
                (Control_Signal[9] & Control_Signal[8])), 32'd0);
    end
  end

  // ----------------------------------------------------------------- drivers
  // One operation. rst_at >= 0 aborts with reset at that cycle; s1/s2 >= 0
  // pulse Start at those cycles while busy. Cycle 0 is the LOAD cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                        input int rst_at, input int s1, input int s2);
    int         cyc;
    int         done_cyc;
    int         busy_cnt;
    int         add_cnt;
    int         ph;
    int         extra_dones;
    logic [7:0] exp_c;
    logic [14:0] exp_ctrl;
    a_in = a; b_in = b; n_in = n;
    exp_c = 8'((int'(a) * int'(b)) % int'(n));
    @(negedge clk); Start = 1'b1;
    @(negedge clk); Start = 1'b0;
    cyc = 0; done_cyc = -1; busy_cnt = 0; add_cnt = 0;
    check("load_ctrl", 32'(Control_Signal), 32'h7A00);
    while (1) begin
      if (Busy) busy_cnt++;
      if (Control_Signal[9] && Control_Signal[3:2] == 2'b10) add_cnt++;
      if (cyc >= 1 && cyc <= 6 * K + 1) begin
        ph = (cyc - 1) % 6;
        case (ph)
          0:       exp_ctrl = 15'h0000;
          1:       exp_ctrl = 15'h0100;
          3:       exp_ctrl = b_reg[7] ? 15'h021A : 15'h0000;
          5:       exp_ctrl = 15'h1481;
          default: exp_ctrl = (c_reg >= n_reg) ? 15'h0277 : 15'h0060;
        endcase
        check($sformatf("ctrl_c%0d", cyc), 32'(Control_Signal), 32'(exp_ctrl));
      end
      if (Done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ctrl", 32'(Control_Signal), 32'h0);
        check("rst_mid_busy", 32'(Busy), 32'h0);
        check("rst_mid_done", 32'(Done), 32'h0);
        rst = 1'b0;
        extra_dones = 0;
        repeat (60) begin
          @(negedge clk);
          if (Done) extra_dones++;
        end
        check("rst_mid_no_done", 32'(extra_dones), 32'h0);
        return;
      end
      if (cyc >= 120) break;
      if (cyc == s1 || cyc == s2) Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      cyc++;
    end
    check("latency", 32'(done_cyc), 32'(6 * K + 2));
    check($sformatf("result_%0d_%0d_%0d", a, b, n), 32'(c_reg), 32'(exp_c));
    check("done_ctrl", 32'(Control_Signal), 32'h0);
    check("iter_count", 32'(dbg_iter), 32'(K));
    check("busy_cycles", 32'(busy_cnt), 32'(6 * K + 3));
    check("add_count", 32'(add_cnt), 32'($countones(b)));
    @(negedge clk);
    check("after_busy", 32'(Busy), 32'h0);
    check("after_done", 32'(Done), 32'h0);
    if (s1 >= 0) begin
      extra_dones = 0;
      repeat (60) begin
        @(negedge clk);
        if (Done) extra_dones++;
      end
      check("busy_start_ignored", 32'(extra_dones), 32'h0);
    end
  endtask

  // Wait up to max_cyc negedges for Done; returns cycles waited or -1.
  task automatic wait_done(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (Done) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    logic [7:0] ra, rb, rn;
    int         gap;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'(Control_Signal), 32'h0);
    check("reset_busy", 32'(Busy), 32'h0);
    check("reset_done", 32'(Done), 32'h0);
    check("reset_iter", 32'(dbg_iter), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(Busy), 32'h0);

    run_op(8'd5,   8'd7,   8'd11,  -1, -1, -1);
    run_op(8'd0,   8'd200, 8'd13,  -1, -1, -1);
    run_op(8'd9,   8'd0,   8'd13,  -1, -1, -1);
    run_op(8'd100, 8'd200, 8'd127, -1, -1, -1);
    run_op(8'd127, 8'd255, 8'd128, -1, -1, -1);
    run_op(8'd0,   8'd255, 8'd1,   -1, -1, -1);

    run_op(8'd5, 8'd7, 8'd11, 20, -1, -1);
    run_op(8'd5, 8'd7, 8'd11, -1, -1, -1);

    run_op(8'd5, 8'd7, 8'd11, -1, 10, 30);

    for (int t = 0; t < 10; t++) begin
      rn = 8'($urandom_range(128, 1));
      ra = 8'($urandom_range(int'(rn) - 1, 0));
      rb = 8'($urandom_range(255, 0));
      run_op(ra, rb, rn, -1, -1, -1);
    end

    // Start held high: back-to-back operations.
    a_in = 8'd100; b_in = 8'd200; n_in = 8'd127;
    @(negedge clk); Start = 1'b1;
    wait_done(120, gap);
    check("held_first_done", 32'(gap > 0), 32'h1);
    check("held_result1", 32'(c_reg), 32'd61);
    wait_done(120, gap);
    Start = 1'b0;
    check("held_gap", 32'(gap), 32'd52);
    check("held_result2", 32'(c_reg), 32'd61);
    repeat (3) @(negedge clk);
    check("held_idle_busy", 32'(Busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
